// File: rtl/data_mem_sb_if.sv
// CPU load/store port of the data-memory subsystem.
// The master side is the CPU; the slave side is data_mem_sb.
interface data_mem_sb_if #(
   parameter int W        = 32,
   parameter int SB_DEPTH = 4
);
   localparam int CW = $clog2(SB_DEPTH + 1);

   logic          load_en;
   logic [W-1:0]  l_addr;
   logic [W-1:0]  l_data;
   logic          l_valid;
   logic          store_en;
   logic [W-1:0]  s_addr;
   logic [W-1:0]  s_data;
   logic          stall;
   logic [CW-1:0] sb_count;
   logic          sb_empty;

   modport master (
      output load_en, l_addr, store_en, s_addr, s_data,
      input  l_data, l_valid, stall, sb_count, sb_empty
   );

   modport slave (
      input  load_en, l_addr, store_en, s_addr, s_data,
      output l_data, l_valid, stall, sb_count, sb_empty
   );
endinterface

// File: rtl/data_mem_sb.sv
// Data-memory subsystem: single-ported word RAM behind a posted-store FIFO.
// Loads forward the youngest matching buffered store, otherwise read the RAM
// with RD_LAT cycles of latency. Buffered stores drain whenever a load miss
// is not using the RAM port.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | accepting loads and stores; drain runs when RAM port is free
// S_RD_WAIT | load miss in flight; CPU stalled, no push and no drain
module data_mem_sb #(
   parameter int W         = 32,
   parameter int ADDR_BITS = 10,
   parameter int SB_DEPTH  = 4,
   parameter int RD_LAT    = 2
) (
   input  logic         clk,
   input  logic         rst,
   data_mem_sb_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_BITS;
   localparam int PW    = $clog2(SB_DEPTH);
   localparam int CW    = $clog2(SB_DEPTH + 1);

   typedef enum logic {
      S_IDLE    = 1'b0,
      S_RD_WAIT = 1'b1
   } state_t;

   state_t               r_state;
   logic [2:0]           r_cnt;
   logic [W-1:0]         r_l_data;
   logic                 r_l_valid;

   logic [ADDR_BITS-1:0] r_sb_idx  [SB_DEPTH];
   logic [W-1:0]         r_sb_data [SB_DEPTH];
   logic [PW-1:0]        r_wp;
   logic [PW-1:0]        r_rp;
   logic [CW-1:0]        r_count;

   logic [W-1:0]         r_mem [DEPTH];
   logic [W-1:0]         r_rd_data;

   logic [ADDR_BITS-1:0] w_l_idx;
   logic [ADDR_BITS-1:0] w_s_idx;
   logic                 w_idle;
   logic                 w_full;
   logic                 w_push;
   logic                 w_ld_acc;
   logic                 w_hit;
   logic                 w_miss;
   logic                 w_pop;
   logic [W-1:0]         w_fwd_data;
   logic                 w_unused_addr;

   // Byte offset and bits above the RAM index are ignored, so addresses alias.
   assign w_l_idx       = bus.l_addr[ADDR_BITS+1:2];
   assign w_s_idx       = bus.s_addr[ADDR_BITS+1:2];
   assign w_unused_addr = ^{bus.l_addr[W-1:ADDR_BITS+2], bus.l_addr[1:0],
                            bus.s_addr[W-1:ADDR_BITS+2], bus.s_addr[1:0]};

   assign w_idle   = (r_state == S_IDLE);
   assign w_full   = (r_count == CW'(SB_DEPTH));
   assign w_push   = bus.store_en && !w_full && w_idle;
   assign w_ld_acc = bus.load_en && w_idle;
   assign w_miss   = w_ld_acc && !w_hit;
   // A load miss owns the RAM port this cycle, so the drain waits.
   assign w_pop    = (r_count != '0) && w_idle && !w_miss;

   // Forwarding search: walk valid entries oldest to youngest, last match wins.
   // A store pushed this same cycle is not yet visible here, which keeps it
   // younger than a simultaneous load.
   always_comb begin
      logic [PW-1:0] pos;
      w_hit      = 1'b0;
      w_fwd_data = '0;
      pos        = '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
         pos = r_rp + PW'(i);
         if ((CW'(i) < r_count) && (r_sb_idx[pos] == w_l_idx)) begin
            w_hit      = 1'b1;
            w_fwd_data = r_sb_data[pos];
         end
      end
   end

   // Storage arrays and RAM; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_sb_idx[r_wp]  <= w_s_idx;
         r_sb_data[r_wp] <= bus.s_data;
      end
      if (w_pop) begin
         r_mem[r_sb_idx[r_rp]] <= r_sb_data[r_rp];
      end
      if (w_miss) begin
         r_rd_data <= r_mem[w_l_idx];
      end
   end

   // Control FSM, FIFO pointers and registered load response.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_l_data  <= '0;
         r_l_valid <= 1'b0;
         r_wp      <= '0;
         r_rp      <= '0;
         r_count   <= '0;
      end else begin
         r_l_valid <= 1'b0;
         if (w_push) begin
            r_wp <= r_wp + 1'b1;
         end
         if (w_pop) begin
            r_rp <= r_rp + 1'b1;
         end
         r_count <= r_count + CW'(w_push) - CW'(w_pop);

         case (r_state)
            S_IDLE: begin
               if (w_ld_acc) begin
                  if (w_hit) begin
                     r_l_data  <= w_fwd_data;
                     r_l_valid <= 1'b1;
                  end else if (RD_LAT == 1) begin
                     r_l_data  <= r_mem[w_l_idx];
                     r_l_valid <= 1'b1;
                  end else begin
                     r_state <= S_RD_WAIT;
                     r_cnt   <= 3'(RD_LAT - 1);
                  end
               end
            end
            S_RD_WAIT: begin
               // r_cnt counts the wait cycles still to go, including this one.
               if (r_cnt <= 3'd1) begin
                  r_l_data  <= r_rd_data;
                  r_l_valid <= 1'b1;
                  r_cnt     <= '0;
                  r_state   <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt - 3'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.l_data   = r_l_data;
   assign bus.l_valid  = r_l_valid;
   assign bus.stall    = (w_full && bus.store_en) || (r_state == S_RD_WAIT);
   assign bus.sb_count = r_count;
   assign bus.sb_empty = (r_count == '0);
endmodule

// File: tb/tb_data_mem_sb.sv
// Bench for data_mem_sb: directed scenarios followed by random load/store
// traffic, all checked against a queue-based model of the store buffer and RAM.
module tb_data_mem_sb;
   localparam int W         = 32;
   localparam int ADDR_BITS = 10;
   localparam int SB_DEPTH  = 4;
   localparam int RD_LAT    = 2;

   typedef struct packed {
      logic [ADDR_BITS-1:0] idx;
      logic [W-1:0]         data;
   } ent_t;

   logic clk;
   logic rst;

   data_mem_sb_if #(.W(W), .SB_DEPTH(SB_DEPTH)) bus ();

   data_mem_sb #(
      .W(W), .ADDR_BITS(ADDR_BITS), .SB_DEPTH(SB_DEPTH), .RD_LAT(RD_LAT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: pending stores in program order, plus RAM contents.
   ent_t         q[$];
   logic [W-1:0] ram_m [int];
   int           wait_rem;
   logic [W-1:0] pend;
   logic [W-1:0] exp_ldata;
   int           checks;
   int           errors;
   int           peak;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic logic [ADDR_BITS-1:0] idx_of(input logic [W-1:0] a);
      return a[ADDR_BITS+1:2];
   endfunction

   // One clock cycle: drive the request, check combinational outputs before
   // the edge, advance the model by the buffer/RAM rules, check after the edge.
   task automatic step(input bit le, input logic [W-1:0] la,
                       input bit se, input logic [W-1:0] sa, input logic [W-1:0] sd);
      bit           busy, full, hit, miss, push, pop, nxt_valid;
      logic [W-1:0] fwd;
      ent_t         e;
      bus.load_en  = le;
      bus.l_addr   = la;
      bus.store_en = se;
      bus.s_addr   = sa;
      bus.s_data   = sd;
      @(negedge clk);
      busy = (wait_rem > 0);
      full = (q.size() == SB_DEPTH);
      chk("stall",    {31'b0, bus.stall},   {31'b0, (full && se) || busy});
      chk("sb_count", {29'b0, bus.sb_count}, q.size());
      chk("sb_empty", {31'b0, bus.sb_empty}, {31'b0, q.size() == 0});
      nxt_valid = 1'b0;
      if (busy) begin
         wait_rem--;
         if (wait_rem == 0) begin
            nxt_valid = 1'b1;
            exp_ldata = pend;
         end
      end else begin
         hit = 1'b0;
         fwd = '0;
         if (le) begin
            foreach (q[i]) if (q[i].idx == idx_of(la)) begin
               hit = 1'b1;
               fwd = q[i].data;
            end
         end
         miss = le && !hit;
         push = se && !full;
         pop  = (q.size() > 0) && !miss;
         if (hit) begin
            nxt_valid = 1'b1;
            exp_ldata = fwd;
         end else if (miss) begin
            fwd = ram_m.exists(int'(idx_of(la))) ? ram_m[int'(idx_of(la))] : 'x;
            if (RD_LAT == 1) begin
               nxt_valid = 1'b1;
               exp_ldata = fwd;
            end else begin
               wait_rem = RD_LAT - 1;
               pend     = fwd;
            end
         end
         if (pop) begin
            ram_m[int'(q[0].idx)] = q[0].data;
            void'(q.pop_front());
         end
         if (push) begin
            e.idx  = idx_of(sa);
            e.data = sd;
            q.push_back(e);
         end
      end
      @(posedge clk);
      #1;
      chk("l_valid", {31'b0, bus.l_valid}, {31'b0, nxt_valid});
      chk("l_data",  bus.l_data, exp_ldata);
      if (int'(bus.sb_count) > peak) peak = int'(bus.sb_count);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, '0, 0, '0, '0);
   endtask

   task automatic do_reset();
      bus.load_en  = 1'b0;
      bus.store_en = 1'b0;
      bus.l_addr   = '0;
      bus.s_addr   = '0;
      bus.s_data   = '0;
      rst = 1'b0;
      #1;
      q.delete();
      wait_rem  = 0;
      exp_ldata = '0;
      chk("rst_l_valid",  {31'b0, bus.l_valid},  32'd0);
      chk("rst_l_data",   bus.l_data,            32'd0);
      chk("rst_stall",    {31'b0, bus.stall},    32'd0);
      chk("rst_sb_count", {29'b0, bus.sb_count}, 32'd0);
      chk("rst_sb_empty", {31'b0, bus.sb_empty}, 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_l_valid", {31'b0, bus.l_valid}, 32'd0);
   endtask

   initial begin
      logic [W-1:0] a, b;
      checks   = 0;
      errors   = 0;
      peak     = 0;
      wait_rem = 0;
      pend     = '0;
      exp_ldata = '0;
      rst = 1'b0;
      bus.load_en = 1'b0; bus.store_en = 1'b0;
      bus.l_addr = '0; bus.s_addr = '0; bus.s_data = '0;
      @(posedge clk);
      #1;
      do_reset();

      // Scenario 1: store then immediate load forwards from the buffer.
      step(0, '0, 1, 32'h10, 32'hDEADBEEF);
      step(1, 32'h10, 0, '0, '0);
      chk("t1_l_valid", {31'b0, bus.l_valid}, 32'd1);
      chk("t1_l_data",  bus.l_data, 32'hDEADBEEF);

      // Give every word index 0..15 a known RAM value.
      for (int i = 0; i < 16; i++) step(0, '0, 1, i * 4, $urandom);
      idle(2);

      // Scenario 2: each store paired with a load miss blocks the drain.
      peak = 0;
      for (int i = 0; i < 4; i++) begin
         step(1, i * 4, 1, 32'h100 + i * 4, 32'hA000 + i);
         idle(RD_LAT - 1);
      end
      chk("t2_peak", peak, 32'd4);
      step(0, '0, 1, 32'h114, 32'hA004);
      step(0, '0, 1, 32'h114, 32'hA004);
      idle(5);

      // Scenario 3: two buffered stores to one word, youngest forwarded.
      step(1, 32'h4, 1, 32'h20, 32'h1);
      idle(RD_LAT - 1);
      step(1, 32'h8, 1, 32'h20, 32'h2);
      idle(RD_LAT - 1);
      step(1, 32'h20, 0, '0, '0);
      chk("t3_l_data", bus.l_data, 32'h2);

      // Scenario 4: drained word comes back from RAM after RD_LAT cycles.
      idle(4);
      step(1, 32'h20, 0, '0, '0);
      idle(RD_LAT - 1);
      chk("t4_l_data", bus.l_data, 32'h2);

      // Scenario 5: same-cycle load and store; load sees the older RAM value.
      step(0, '0, 1, 32'h30, 32'h5);
      idle(2);
      step(1, 32'h30, 1, 32'h30, 32'h7);
      idle(RD_LAT - 1);
      chk("t5_old", bus.l_data, 32'h5);
      step(1, 32'h30, 0, '0, '0);
      chk("t5_new", bus.l_data, 32'h7);
      idle(3);

      // Scenario 6: reset during a miss with two stores buffered.
      a = ram_m[int'(idx_of(32'h14))];
      b = ram_m[int'(idx_of(32'h18))];
      step(0, '0, 1, 32'h14, 32'h1111);
      step(1, 32'h1C, 1, 32'h18, 32'h2222);
      do_reset();
      idle(3);
      step(1, 32'h14, 0, '0, '0);
      idle(RD_LAT - 1);
      chk("t6_ram_a", bus.l_data, a);
      step(1, 32'h18, 0, '0, '0);
      idle(RD_LAT - 1);
      chk("t6_ram_b", bus.l_data, b);

      // Random traffic over aliased addresses of word indices 0..15.
      for (int n = 0; n < 400; n++) begin
         logic [W-1:0] ra, wa;
         ra = $urandom;
         wa = $urandom;
         ra[ADDR_BITS+1:2] = ADDR_BITS'($urandom_range(0, 15));
         wa[ADDR_BITS+1:2] = ADDR_BITS'($urandom_range(0, 15));
         step($urandom_range(0, 1) == 1, ra, $urandom_range(0, 2) != 0, wa, $urandom);
      end
      idle(6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
